// File: rtl/snitch_fpu_shared.sv
// Shares one FPU port among NumHarts cores: round-robin request arbiter,
// registered request stage, tag-based response routing, per-hart in-flight limits.
// Optional: define SNITCH_FPU_SHARED_RSP_BUF_EN for a 2-entry response FIFO.
module snitch_fpu_shared #(
    parameter int unsigned NumHarts       = 4,
    parameter int unsigned TagWidth       = 6,
    parameter int unsigned ReqWidth       = 200,
    parameter int unsigned FLEN           = 64,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdxW           = $clog2(NumHarts)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumHarts-1:0]          req_valid_i,
    output logic [NumHarts-1:0]          req_ready_o,
    input  logic [NumHarts*TagWidth-1:0] req_tag_i,
    input  logic [NumHarts*ReqWidth-1:0] req_data_i,
    output logic                         fpu_valid_o,
    input  logic                         fpu_ready_i,
    output logic [ReqWidth-1:0]          fpu_data_o,
    output logic [IdxW+TagWidth-1:0]     fpu_tag_o,
    input  logic                         fpu_rsp_valid_i,
    output logic                         fpu_rsp_ready_o,
    input  logic [FLEN-1:0]              fpu_rsp_result_i,
    input  logic [4:0]                   fpu_rsp_status_i,
    input  logic [IdxW+TagWidth-1:0]     fpu_rsp_tag_i,
    output logic [NumHarts-1:0]          rsp_valid_o,
    input  logic [NumHarts-1:0]          rsp_ready_i,
    output logic [FLEN-1:0]              rsp_result_o,
    output logic [4:0]                   rsp_status_o,
    output logic [TagWidth-1:0]          rsp_tag_o,
    output logic                         err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam bit          Pow2 = ((1 << IdxW) == NumHarts);

    logic [CntW-1:0]          cnt_q [NumHarts];
    logic [IdxW-1:0]          ptr_q;
    logic                     stg_vld_q;
    logic [ReqWidth-1:0]      stg_data_q;
    logic [IdxW+TagWidth-1:0] stg_tag_q;
    logic                     err_q;

    logic [NumHarts-1:0] elig;
    logic                gnt_vld;
    logic [IdxW-1:0]     gnt_idx;
    int unsigned         hh;
    logic                can_acc;
    logic                accept;

    logic [IdxW-1:0] in_idx;
    logic            in_ok;
    logic            dec_vld;
    logic [IdxW-1:0] dec_idx;
    logic            err_set;

    // Eligibility: valid request and room below the in-flight limit
    always_comb begin
        elig = '0;
        for (int unsigned h = 0; h < NumHarts; h++) begin
            elig[h] = req_valid_i[h] && (cnt_q[h] < CntW'(MaxOutstanding));
        end
    end

    // Round-robin search starting at the pointer, wrapping around
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        hh      = 0;
        for (int unsigned i = 0; i < NumHarts; i++) begin
            hh = (32'(ptr_q) + i) % NumHarts;
            if (!gnt_vld && elig[IdxW'(hh)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IdxW'(hh);
            end
        end
    end

    assign can_acc = !stg_vld_q || fpu_ready_i;
    assign accept  = gnt_vld && can_acc;

    // Ready only towards the granted hart, when the stage can take it
    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[gnt_idx] = 1'b1;
    end

    // Pointer moves past the hart that was just served
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (gnt_idx == IdxW'(NumHarts - 1)) ? '0 : gnt_idx + IdxW'(1);
        end
    end

    // Request stage: load on accept, drain on FPU handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            stg_tag_q  <= '0;
        end else if (accept) begin
            stg_vld_q  <= 1'b1;
            stg_data_q <= req_data_i[gnt_idx*ReqWidth +: ReqWidth];
            stg_tag_q  <= {gnt_idx, req_tag_i[gnt_idx*TagWidth +: TagWidth]};
        end else if (fpu_ready_i) begin
            stg_vld_q  <= 1'b0;
        end
    end

    assign fpu_valid_o = stg_vld_q;
    assign fpu_data_o  = stg_data_q;
    assign fpu_tag_o   = stg_tag_q;

    assign in_idx = fpu_rsp_tag_i[IdxW+TagWidth-1 -: IdxW];
    assign in_ok  = Pow2 ? 1'b1
                  : ({1'b0, in_idx} < (IdxW+1)'(NumHarts));

`ifdef SNITCH_FPU_SHARED_RSP_BUF_EN
    typedef struct packed {
        logic [FLEN-1:0]          res;
        logic [4:0]               st;
        logic [IdxW+TagWidth-1:0] tag;
    } rsp_ent_t;

    rsp_ent_t        fifo_q [2];
    logic [1:0]      fcnt_q;
    logic            wr_q;
    logic            rd_q;
    logic            full;
    logic            enq;
    logic            deq;
    logic            hd_vld;
    rsp_ent_t        hd;
    logic [IdxW-1:0] hd_idx;

    assign full    = (fcnt_q == 2'd2);
    assign enq     = fpu_rsp_valid_i && !full && in_ok;
    assign err_set = fpu_rsp_valid_i && !full && !in_ok;
    assign hd_vld  = (fcnt_q != 2'd0);
    assign hd      = fifo_q[rd_q];
    assign hd_idx  = hd.tag[IdxW+TagWidth-1 -: IdxW];
    assign deq     = hd_vld && rsp_ready_i[hd_idx];

    assign fpu_rsp_ready_o = !full;
    assign rsp_result_o    = hd.res;
    assign rsp_status_o    = hd.st;
    assign rsp_tag_o       = hd.tag[TagWidth-1:0];
    assign dec_vld         = deq;
    assign dec_idx         = hd_idx;

    // Route the FIFO head to its hart
    always_comb begin
        rsp_valid_o = '0;
        if (hd_vld) rsp_valid_o[hd_idx] = 1'b1;
    end

    // Two-entry response FIFO; out-of-range responses never enter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fcnt_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            if (enq) begin
                fifo_q[wr_q] <= '{res: fpu_rsp_result_i,
                                  st:  fpu_rsp_status_i,
                                  tag: fpu_rsp_tag_i};
                wr_q <= ~wr_q;
            end
            if (deq) rd_q <= ~rd_q;
            fcnt_q <= fcnt_q + 2'(enq) - 2'(deq);
        end
    end
`else
    assign fpu_rsp_ready_o = in_ok ? rsp_ready_i[in_idx] : 1'b1;
    assign rsp_result_o    = fpu_rsp_result_i;
    assign rsp_status_o    = fpu_rsp_status_i;
    assign rsp_tag_o       = fpu_rsp_tag_i[TagWidth-1:0];
    assign dec_vld         = fpu_rsp_valid_i && in_ok && rsp_ready_i[in_idx];
    assign dec_idx         = in_idx;
    assign err_set         = fpu_rsp_valid_i && !in_ok;

    // Steer the response valid to the hart named in the tag
    always_comb begin
        rsp_valid_o = '0;
        if (fpu_rsp_valid_i && in_ok) rsp_valid_o[in_idx] = 1'b1;
    end
`endif

    // In-flight counters: +1 on grant, -1 on response, saturating at 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned h = 0; h < NumHarts; h++) cnt_q[h] <= '0;
        end else begin
            for (int unsigned h = 0; h < NumHarts; h++) begin
                if (accept && gnt_idx == IdxW'(h)) begin
                    if (!(dec_vld && dec_idx == IdxW'(h)))
                        cnt_q[h] <= cnt_q[h] + CntW'(1);
                end else if (dec_vld && dec_idx == IdxW'(h)) begin
                    if (cnt_q[h] != '0) cnt_q[h] <= cnt_q[h] - CntW'(1);
                end
            end
        end
    end

    // Sticky flag for responses naming a hart that does not exist
    always_ff @(posedge clk_i) begin
        if (rst_i)        err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign err_o = err_q;

endmodule
